// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream blocks: arbiter FSM state
// encoding and the round-robin pick function.
package axis_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Widest request vector rr_pick accepts; callers zero-extend into it.
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = 5;

    // Returns the first set bit of req searching upward from ptr+1 and
    // wrapping modulo n. Only meaningful when some req bit below n is set.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                            input int unsigned       ptr,
                                            input int unsigned       n);
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = 0;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (i <= n) && req[idx[RR_IDX_W-1:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register. Loads when load_i is high,
// drains when the consumer takes the beat and nothing new arrives. space_o
// tells the upstream side whether a load this cycle is allowed.
module axis_out_reg #(
    parameter int WORDS_PER_BEAT = 4,
    parameter int WORD_W         = 8,
    parameter int SEL_W          = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   load_i,
    input  logic                                   last_i,
    input  logic [WORDS_PER_BEAT-1:0]              keep_i,
    input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  data_i,
    input  logic [SEL_W-1:0]                       sel_i,
    input  logic                                   ready_i,
    output logic                                   valid_o,
    output logic                                   last_o,
    output logic [WORDS_PER_BEAT-1:0]              keep_o,
    output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  data_o,
    output logic [SEL_W-1:0]                       sel_o,
    output logic                                   space_o
);

    // Registered output: space only depends on our own valid and the
    // consumer's ready, so no path runs from ready into the data regs.
    assign space_o = !valid_o || ready_i;

    // Load a new beat, or drop valid once the held beat has been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            keep_o  <= '0;
            data_o  <= '0;
            sel_o   <= '0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            last_o  <= last_i;
            keep_o  <= keep_i;
            data_o  <= data_i;
            sel_o   <= sel_i;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: merges N_S AXI-Stream sources onto one
// registered master port, switching sources only after an s_last beat.
//
// Handshake: a beat moves on any interface at a rising edge where its
// valid and ready are both high; a source holding valid keeps its beat
// stable until accepted, and the master side holds m_* stable while
// m_valid is high and m_ready is low.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int N_S            = 4,
    parameter int WORD_W         = 8,
    parameter int BUS_W          = 32,
    parameter int WORDS_PER_BEAT = BUS_W / WORD_W,
    parameter int SEL_W          = $clog2(N_S)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [N_S-1:0]                                  s_valid,
    output logic [N_S-1:0]                                  s_ready,
    input  logic [N_S-1:0]                                  s_last,
    input  logic [N_S-1:0][WORDS_PER_BEAT-1:0]              s_keep,
    input  logic [N_S-1:0][WORDS_PER_BEAT-1:0][WORD_W-1:0]  s_data,
    output logic                                            m_valid,
    input  logic                                            m_ready,
    output logic                                            m_last,
    output logic [WORDS_PER_BEAT-1:0]                       m_keep,
    output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]           m_data,
    output logic [SEL_W-1:0]                                m_sel,
    output logic                                            busy
);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              out_space;
    logic              xfer;
    logic [RR_MAX-1:0] req_ext;

    assign req_ext = RR_MAX'(s_valid);
    assign xfer    = (state_q == LOCKED) && s_valid[sel_q] && out_space;

    // State register: ptr starts at the last source so source 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(N_S - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: grant in IDLE, release at the accepted end-of-packet beat.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|s_valid) begin
                    state_d = LOCKED;
                    sel_d   = SEL_W'(rr_pick(req_ext, 32'(ptr_q), N_S));
                end
            end
            LOCKED: begin
                if (xfer && s_last[sel_q]) begin
                    state_d = IDLE;
                    ptr_d   = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: only the locked source sees ready, gated by output space.
    always_comb begin
        s_ready = '0;
        busy    = (state_q == LOCKED);
        if (state_q == LOCKED) begin
            s_ready[sel_q] = out_space;
        end
    end

    axis_out_reg #(
        .WORDS_PER_BEAT (WORDS_PER_BEAT),
        .WORD_W         (WORD_W),
        .SEL_W          (SEL_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (xfer),
        .last_i  (s_last[sel_q]),
        .keep_i  (s_keep[sel_q]),
        .data_i  (s_data[sel_q]),
        .sel_i   (sel_q),
        .ready_i (m_ready),
        .valid_o (m_valid),
        .last_o  (m_last),
        .keep_o  (m_keep),
        .data_o  (m_data),
        .sel_o   (m_sel),
        .space_o (out_space)
    );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-source beat queues feed the DUT, the
// expected output order is queued as packets are loaded, and a monitor
// pops and compares every beat the sink accepts.
module tb_axis_rr_arbiter;
    localparam int N_S    = 4;
    localparam int WORD_W = 8;
    localparam int WPB    = 4;
    localparam int SEL_W  = 2;

    logic                                 clk;
    logic                                 rst;
    logic [N_S-1:0]                       s_valid;
    logic [N_S-1:0]                       s_ready;
    logic [N_S-1:0]                       s_last;
    logic [N_S-1:0][WPB-1:0]              s_keep;
    logic [N_S-1:0][WPB-1:0][WORD_W-1:0]  s_data;
    logic                                 m_valid;
    logic                                 m_ready;
    logic                                 m_last;
    logic [WPB-1:0]                       m_keep;
    logic [WPB-1:0][WORD_W-1:0]           m_data;
    logic [SEL_W-1:0]                     m_sel;
    logic                                 busy;

    // source beat: {last, keep, data}; expected beat: {sel, last, keep, data}
    logic [36:0] src_q [N_S][$];
    logic [38:0] exp_q [$];
    int          fire_cyc [$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   words_rx = 0;
    logic log_fires = 1'b0;
    logic rand_ready = 1'b0;
    logic ready_fixed = 1'b1;

    axis_rr_arbiter #(.N_S(N_S), .WORD_W(WORD_W), .BUS_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .s_keep  (s_keep),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_keep  (m_keep),
        .m_data  (m_data),
        .m_sel   (m_sel),
        .busy    (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rst = 1'b1;
        s_valid = '0;
        s_last = '0;
        s_keep = '0;
        s_data = '0;
        m_ready = 1'b0;
    end

    // source driver: pop accepted beats, present the next head beat
    initial begin
        logic [N_S-1:0] fire;
        logic [36:0]    rec;
        forever begin
            @(negedge clk);
            fire = s_valid & s_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < N_S; s++) begin
                if (fire[s] && !rst && src_q[s].size() > 0) begin
                    void'(src_q[s].pop_front());
                    if (log_fires) fire_cyc.push_back(cyc);
                end
                if (src_q[s].size() > 0) begin
                    rec        = src_q[s][0];
                    s_valid[s] = 1'b1;
                    s_last[s]  = rec[36];
                    s_keep[s]  = rec[35:32];
                    s_data[s]  = rec[31:0];
                end else begin
                    s_valid[s] = 1'b0;
                    s_last[s]  = 1'b0;
                    s_keep[s]  = '0;
                    s_data[s]  = '0;
                end
            end
        end
    end

    // sink ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? ($urandom_range(0, 99) < 20) : ready_fixed;
        end
    end

    // scoreboard monitor: compare accepted beats, stability while stalled
    initial begin
        logic        stall_prev;
        logic [39:0] held;
        logic [38:0] exp_b;
        logic [38:0] got_b;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                checks++;
                if ($countones(s_ready) > 1) begin
                    errors++;
                    $display("FAIL s_ready_onehot: got %b, need at most one bit", s_ready);
                end
                got_b = {m_sel, m_last, m_keep, m_data};
                if (stall_prev) begin
                    checks++;
                    if ({m_valid, got_b} !== held) begin
                        errors++;
                        $display("FAIL stall_stable: got %h, need %h", {m_valid, got_b}, held);
                    end
                end
                if (m_valid && m_ready) begin
                    checks++;
                    words_rx += $countones(m_keep);
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got %h, need no beat", got_b);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (got_b !== exp_b) begin
                            errors++;
                            $display("FAIL beat: got sel/last/keep/data %h, need %h", got_b, exp_b);
                        end
                    end
                end
                stall_prev = m_valid && !m_ready;
                held = {m_valid, got_b};
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        for (int s = 0; s < N_S; s++) src_q[s].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // queue an n-beat packet on source s; word j of beat b = base+4b+j
    task automatic load_pkt(input int s, input int n, input int base, input logic [3:0] last_keep);
        for (int b = 0; b < n; b++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        l;
            for (int j = 0; j < WPB; j++) d[j*8 +: 8] = 8'(base + b*4 + j);
            l = (b == n - 1);
            k = l ? last_keep : 4'hF;
            src_q[s].push_back({l, k, d});
            exp_q.push_back({2'(s), l, k, d});
        end
    endtask

    task automatic wait_drain(input int budget);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            #2;
            n++;
            done = (exp_q.size() == 0) && !m_valid;
            for (int s = 0; s < N_S; s++) if (src_q[s].size() != 0) done = 1'b0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding after %0d cycles, need 0", exp_q.size(), budget);
            for (int s = 0; s < N_S; s++) src_q[s].delete();
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({m_valid, m_last, m_keep, m_data, m_sel, busy, s_ready} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h, need 0",
                         {m_valid, m_last, m_keep, m_data, m_sel, busy, s_ready});
            end
        end
    endtask

    task automatic test_single_source();
        apply_reset();
        @(negedge clk);
        load_pkt(2, 3, 1, 4'hF);
        @(negedge clk);
        checks++;
        if ({s_valid[2], s_ready, m_valid} !== {1'b1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL single_req_cycle: got valid2/ready/mvalid %b, need 1_0000_0",
                     {s_valid[2], s_ready, m_valid});
        end
        @(negedge clk);
        checks++;
        if ({s_ready, busy, m_valid} !== {4'b0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_grant_cycle: got ready/busy/mvalid %b, need 0100_1_0",
                     {s_ready, busy, m_valid});
        end
        @(negedge clk);
        checks++;
        if ({m_valid, m_sel} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL single_first_beat: got mvalid/msel %b, need 1_10", {m_valid, m_sel});
        end
        wait_drain(100);
    endtask

    task automatic test_round_robin();
        apply_reset();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < N_S; s++) begin
                load_pkt(s, 2, 16*(4*p + s), (s == 2 && p == 0) ? 4'h0 : 4'hF);
            end
        end
        wait_drain(200);
    endtask

    task automatic test_backpressure();
        apply_reset();
        rand_ready = 1'b1;
        words_rx = 0;
        @(negedge clk);
        load_pkt(1, 5, int'($urandom_range(0, 200)), 4'h3);
        wait_drain(1000);
        rand_ready = 1'b0;
        checks++;
        if (words_rx != 18) begin
            errors++;
            $display("FAIL bp_word_count: got %0d, need 18", words_rx);
        end
    endtask

    task automatic test_back_to_back_single();
        apply_reset();
        fire_cyc.delete();
        log_fires = 1'b1;
        @(negedge clk);
        load_pkt(0, 1, 100, 4'hF);
        load_pkt(3, 1, 110, 4'hF);
        load_pkt(0, 1, 120, 4'hF);
        load_pkt(3, 1, 130, 4'hF);
        wait_drain(100);
        log_fires = 1'b0;
        checks++;
        if (fire_cyc.size() != 4) begin
            errors++;
            $display("FAIL b2b_fire_count: got %0d, need 4", fire_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (fire_cyc[i] - fire_cyc[i-1] != 2) begin
                    errors++;
                    $display("FAIL b2b_gap: got %0d cycles, need 2", fire_cyc[i] - fire_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        apply_reset();
        @(negedge clk);
        load_pkt(1, 1, 200, 4'hF);
        wait_drain(100);
        @(negedge clk);
        load_pkt(2, 4, 40, 4'hF);
        n = 0;
        while (!(exp_q.size() == 2 && m_valid) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL midrst_reach_beat2: timed out, need beat 2 on output");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, busy, s_ready} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got mvalid/busy/ready %b, need 0", {m_valid, busy, s_ready});
        end
        apply_reset();
        @(negedge clk);
        load_pkt(0, 1, 60, 4'hF);
        load_pkt(3, 1, 70, 4'hF);
        wait_drain(100);
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_back_to_back_single();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that merges N_S AXI-Stream sources onto one AXI-Stream master port, switching only at packet boundaries (`s_last`). It sits between multiple stream producers and a single consumer such as `axis_sink` or a shared DMA path. The output stage is registered, so no combinational path runs from `m_ready` to the data outputs.

## Interface
- `N_S`, 4: number of source ports, ≥2.
- `WORD_W`, 8: word width in bits.
- `BUS_W`, 32: beat width in bits; must be a multiple of `WORD_W`.
- `WORDS_PER_BEAT`, `BUS_W/WORD_W`: derived; do not override.
- `SEL_W`, `$clog2(N_S)`: derived; do not override.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `s_valid`  in  [N_S]  per-source valid.
- `s_ready`  out  [N_S]  per-source ready; at most one bit high.
- `s_last`  in  [N_S]  per-source end of packet.
- `s_keep`  in  [N_S][WORDS_PER_BEAT]  per-source word enables.
- `s_data`  in  [N_S][WORDS_PER_BEAT][WORD_W]  per-source data.
- `m_valid`  out  1  output valid.
- `m_ready`  in  1  output ready.
- `m_last`  out  1  output end of packet.
- `m_keep`  out  [WORDS_PER_BEAT]  output word enables.
- `m_data`  out  [WORDS_PER_BEAT][WORD_W]  output data.
- `m_sel`  out  SEL_W  source index of the beat on `m_*`.
- `busy`  out  1  high while in LOCKED.

## Operation
- FSM has two states: IDLE and LOCKED.
- **IDLE:**
  - All `s_ready` bits are 0.
  - If any `s_valid` is high, grant the first requester searching upward from `ptr+1` modulo N_S.
  - Latch the granted index into `sel` and go to LOCKED.
  - If no `s_valid` is high, stay in IDLE.
- **LOCKED:**
  - `s_ready[sel] = !m_valid || m_ready`. All other `s_ready` bits are 0.
- **Beat transfer:**
  - A beat transfers when `s_valid[sel] && s_ready[sel]`.
  - On transfer, the output register loads `data`, `keep`, `last` and `sel`, and `m_valid` becomes 1.
- **Output register drain:**
  - The register empties (`m_valid` goes to 0) when `m_valid && m_ready` and no new beat loads in the same cycle.
- **End of packet:**
  - When the transferred beat has `s_last=1`: set `ptr <= sel`, go to IDLE.
- **Pass-through rules:**
  - `keep` and `data` are passed unmodified.
  - An all-zero `keep` beat is forwarded as-is.
  - Words are never reordered.
- **Stall behaviour:**
  - While `m_valid && !m_ready`, all `m_*` outputs and `m_sel` hold stable (AXIS rule).
- **Source gaps:**
  - If the locked source drops `s_valid` mid-packet, the arbiter stays LOCKED indefinitely. There is no timeout and no preemption.
- **Fairness:**
  - After granting source k, source k has the lowest priority in the next arbitration.

## Timing
- **Reset values:**
  - `state` = IDLE.
  - `ptr` = N_S-1, so source 0 wins first.
  - `sel` = 0.
  - `m_valid`, `m_last`, `m_keep`, `m_data`, `m_sel`, `busy`, `s_ready` are all 0.
- **Reset mid-packet:** the beat in the output register is discarded and the packet is truncated. No recovery is attempted.
- **Arbitration latency:** one cycle. A source raising `s_valid` in IDLE at edge t sees `s_ready` high after edge t+1.
- **First-beat latency:** the first beat appears on `m_valid` after edge t+2.
- **Throughput:** one beat per cycle within a packet while `m_ready=1`.
- **Packet switch gap:** exactly one dead input cycle (the IDLE cycle) between packets, even back-to-back from the same source.
- **Single-beat packets:** an input `s_last` beat returns the FSM to IDLE on the same edge it is accepted.
- **Simultaneous requests:** resolved purely by the `ptr` rotation.
- **`m_ready` low on the first beat:** `s_ready[sel]` falls the cycle after the load. The second beat waits.

## Structure
- Package `axis_pkg` holds:
  - `arb_state_t` enum (IDLE, LOCKED).
  - Function `rr_pick(req, ptr)`, which returns the granted index.
- Sub-module `axis_out_reg`:
  - Single-entry output register with the valid/ready logic above.
  - Parameterised by `WORDS_PER_BEAT`, `WORD_W`, `SEL_W`.
  - Reused by later stream blocks.

## Test plan
- **Reset state:** reset, then sources idle → all outputs 0 and `busy=0` for 10 cycles.
- **Single source:** source 2 sends a 3-beat packet, `keep=4'hF`, data 1..12, `m_ready=1` → 12 words in order, `m_sel=2`, `m_last` on beat 3 only, first `m_valid` 2 cycles after `s_valid`.
- **Round-robin order:** all 4 sources continuously offer 2-beat packets → grant order 0,1,2,3,0,… with no interleaving inside a packet.
- **Backpressure:** drive `m_ready` with 20% random-high, source 1 sends a 5-beat packet with partial `keep=4'h3` on the last beat → the sink receives 18 words and no beat is dropped or duplicated. Also check output stability during stalls.
- **Single-beat packets:** sources 0 and 3 send back-to-back 1-beat packets → alternation 0,3,0,3 with the one-cycle gap between grants.
- **Reset mid-packet:** assert `rst` during beat 2 of 4 → `m_valid` drops immediately; after release the next grant goes to source 0.
